// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus shared by two requesters, the arbiter and the UART transmit port.
// The stat_bytes* signals exist only when UART_ARB_STATS_EN is defined.
interface uart_tx_arbiter_if;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STAT_W = 16;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        grant;
    logic [BYTE_W-1:0]       uart_tx_data;
    logic                    uart_tx_wr;
    logic                    uart_tx_busy;
`ifdef UART_ARB_STATS_EN
    logic [STAT_W-1:0]       stat_bytes0;
    logic [STAT_W-1:0]       stat_bytes1;

    // Environment side: requesters plus the UART busy flag
    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, grant, uart_tx_data, uart_tx_wr, stat_bytes0, stat_bytes1
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, grant, uart_tx_data, uart_tx_wr, stat_bytes0, stat_bytes1
    );
`else
    // Environment side: requesters plus the UART busy flag
    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, grant, uart_tx_data, uart_tx_wr
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, grant, uart_tx_data, uart_tx_wr
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmit port between two requesters.
// Define UART_ARB_STATS_EN to add saturating per-requester byte counters.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned N_REQ   = 2;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned IDLE_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_GUARD = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [N_REQ-1:0]   r_grant,     w_grant_nxt;
    logic               r_rr_ptr,    w_rr_ptr_nxt;
    logic [BURST_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [IDLE_W-1:0]  r_idle_cnt,  w_idle_cnt_nxt;
    logic               r_last_f,    w_last_f_nxt;
    logic [BYTE_W-1:0]  r_tx_data,   w_tx_data_nxt;
    logic               r_tx_wr,     w_tx_wr_nxt;
    logic [N_REQ-1:0]   w_req_ready;

    logic               w_gidx;
    logic               w_gvalid;
    logic               w_glast;
    logic [BYTE_W-1:0]  w_gdata;
    logic               w_winner;

    // Current owner's stream, selected by the one-hot grant
    assign w_gidx   = r_grant[1];
    assign w_gvalid = bus.req_valid[w_gidx];
    assign w_glast  = bus.req_last[w_gidx];
    assign w_gdata  = w_gidx ? bus.req_data[2*BYTE_W-1:BYTE_W] : bus.req_data[BYTE_W-1:0];

    // A lone requester wins outright; on a tie the round-robin pointer decides
    assign w_winner = (bus.req_valid == 2'b10) ? 1'b1 :
                      (bus.req_valid == 2'b01) ? 1'b0 : r_rr_ptr;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_idle_cnt_nxt  = r_idle_cnt;
        w_last_f_nxt    = r_last_f;
        w_tx_data_nxt   = r_tx_data;
        w_tx_wr_nxt     = 1'b0;
        w_req_ready     = '0;

        unique case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_grant_nxt     = w_winner ? 2'b10 : 2'b01;
                    w_rr_ptr_nxt    = ~w_winner;
                    w_burst_cnt_nxt = '0;
                    w_idle_cnt_nxt  = '0;
                    w_state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_gvalid && !bus.uart_tx_busy) begin
                    w_req_ready    = r_grant;
                    w_tx_data_nxt  = w_gdata;
                    w_last_f_nxt   = w_glast;
                    w_idle_cnt_nxt = '0;
                    w_tx_wr_nxt    = 1'b1;
                    w_state_nxt    = S_SEND;
                end else if (!w_gvalid) begin
                    // Stalled owner loses the grant once the idle budget is spent
                    if (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
                    end
                end
            end
            S_SEND: begin
                if (r_burst_cnt != '1) begin
                    w_burst_cnt_nxt = r_burst_cnt + BURST_W'(1);
                end
                w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.uart_tx_busy) begin
                    if (r_last_f || (r_burst_cnt == BURST_W'(MAX_BURST))) begin
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= 1'b0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
            r_last_f    <= 1'b0;
            r_tx_data   <= '0;
            r_tx_wr     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_last_f    <= w_last_f_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_wr     <= w_tx_wr_nxt;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.grant        = r_grant;
    assign bus.uart_tx_data = r_tx_data;
    assign bus.uart_tx_wr   = r_tx_wr;

`ifdef UART_ARB_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] r_stat0, w_stat0_nxt;
    logic [STAT_W-1:0] r_stat1, w_stat1_nxt;

    // Saturating count of strobed bytes per owner
    always_comb begin
        w_stat0_nxt = r_stat0;
        w_stat1_nxt = r_stat1;
        if (r_state == S_SEND) begin
            if (!w_gidx && (r_stat0 != '1)) w_stat0_nxt = r_stat0 + STAT_W'(1);
            if ( w_gidx && (r_stat1 != '1)) w_stat1_nxt = r_stat1 + STAT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            r_stat0 <= w_stat0_nxt;
            r_stat1 <= w_stat1_nxt;
        end
    end

    assign bus.stat_bytes0 = r_stat0;
    assign bus.stat_bytes1 = r_stat1;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte FIFOs, session rules and directed timing checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned MAX_BURST    = 4;
    localparam int unsigned IDLE_TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int busy_lo = 1;
    int busy_hi = 1;
    int gap_hi  = 0;
    int busy_cnt = 0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .MAX_BURST    (MAX_BURST),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // UART model: busy rises the cycle after the strobe and lasts a random length
    always @(posedge clk) begin
        if (bus.uart_tx_wr) busy_cnt <= int'($urandom_range(busy_hi, busy_lo));
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.uart_tx_busy = (busy_cnt != 0);

    // Requester drivers: hold valid until accepted, then an optional gap
    for (genvar r = 0; r < 2; r++) begin : g_drv
        logic       v = 1'b0;
        logic [7:0] d = 8'h00;
        logic       l = 1'b0;
        logic [8:0] q[$];
        initial begin
            logic [8:0] e;
            bit         acc;
            int         n;
            forever begin
                if (q.size() == 0) begin
                    @(posedge clk); #1;
                end else begin
                    e = q.pop_front();
                    v = 1'b1; d = e[7:0]; l = e[8];
                    acc = 1'b0; n = 0;
                    while (!acc && n < 5000) begin
                        @(negedge clk); acc = bus.req_ready[r];
                        @(posedge clk); #1; n++;
                    end
                    v = 1'b0;
                    if (!acc) fail($sformatf("drv%0d_accept", r), $sformatf("byte 0x%0h not accepted in %0d cycles", e[7:0], n));
                    repeat ($urandom_range(gap_hi, 0)) begin @(posedge clk); #1; end
                end
            end
        end
    end

    assign bus.req_valid = {g_drv[1].v, g_drv[0].v};
    assign bus.req_data  = {g_drv[1].d, g_drv[0].d};
    assign bus.req_last  = {g_drv[1].l, g_drv[0].l};

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic [8:0] log_q[$];

    task automatic push_byte(input int r, input logic [7:0] dat, input logic last);
        if (r == 0) begin
            g_drv[0].q.push_back({last, dat});
            exp_q0.push_back({last, dat});
        end else begin
            g_drv[1].q.push_back({last, dat});
            exp_q1.push_back({last, dat});
        end
    endtask

    // Monitor: order per requester, burst limit, message boundaries, handshake sanity
    initial begin
        logic [1:0] prev_grant;
        logic       prev_wr;
        int         sess_cnt;
        bit         must_end;
        bit         have;
        logic [8:0] e;
        prev_grant = 2'b00; prev_wr = 1'b0; sess_cnt = 0; must_end = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_grant = 2'b00; prev_wr = 1'b0; sess_cnt = 0; must_end = 1'b0;
            end else begin
                if (prev_grant == 2'b00 && bus.grant != 2'b00) begin
                    sess_cnt = 0; must_end = 1'b0;
                end
                if (bus.req_ready != 2'b00)
                    check("ready_only_to_owner", bus.req_ready & ~bus.grant, 32'd0);
                if (bus.uart_tx_wr) begin
                    check("wr_single_cycle", prev_wr, 1'b0);
                    have = 1'b0;
                    if (bus.grant == 2'b01 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                    else if (bus.grant == 2'b10 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        fail("unexpected_byte", $sformatf("strobe data 0x%0h grant %b, no byte expected", bus.uart_tx_data, bus.grant));
                    end else begin
                        check("tx_data", bus.uart_tx_data, e[7:0]);
                        check("session_released", must_end, 1'b0);
                        sess_cnt++;
                        check("burst_within_limit", sess_cnt <= MAX_BURST, 1'b1);
                        must_end = e[8] || (sess_cnt == MAX_BURST);
                        log_q.push_back({bus.grant[1], bus.uart_tx_data});
                    end
                end
                prev_grant = bus.grant;
                prev_wr    = bus.uart_tx_wr;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 20000 && !(g_drv[0].q.size() == 0 && g_drv[1].q.size() == 0 &&
                              exp_q0.size() == 0 && exp_q1.size() == 0 &&
                              !g_drv[0].v && !g_drv[1].v && bus.grant == 2'b00)) begin
            @(negedge clk); n++;
        end
        if (n >= 20000)
            fail(name, $sformatf("not drained: %0d/%0d bytes outstanding, grant %b", exp_q0.size(), exp_q1.size(), bus.grant));
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.uart_tx_wr && n < 2000);
        if (!bus.uart_tx_wr) fail(name, $sformatf("no strobe within %0d cycles", n));
    endtask

    task automatic wait_grant(input string name, input logic [1:0] g);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.grant != g && n < 2000);
        if (bus.grant != g) fail(name, $sformatf("grant %b, expected %b within %0d cycles", bus.grant, g, n));
    endtask

    task automatic wait_busy_low(input string name);
        int n;
        n = 0;
        while (bus.uart_tx_busy && n < 200) begin @(negedge clk); n++; end
        if (bus.uart_tx_busy) fail(name, "UART busy never dropped");
    endtask

    task automatic compare_log(input string name, input logic [8:0] want[$]);
        check({name, "_count"}, log_q.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < log_q.size()) check($sformatf("%s[%0d]", name, i), log_q[i], want[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] want[$];
        bit         bad;
        int         r, len;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_grant", bus.grant, 2'b00);
        check("reset_wr", bus.uart_tx_wr, 1'b0);
        check("reset_data", bus.uart_tx_data, 8'h00);
        check("reset_ready", bus.req_ready, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single three-byte message, 10-cycle UART
        busy_lo = 10; busy_hi = 10; gap_hi = 0;
        log_q.delete();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        repeat (3) wait_strobe("single_strobe");
        @(negedge clk);
        wait_busy_low("single_drain");
        check("single_grant_in_drain", bus.grant, 2'b01);
        @(negedge clk);
        check("single_release", bus.grant, 2'b00);
        wait_idle("single_idle");
        want.delete();
        want.push_back({1'b0, 8'h41}); want.push_back({1'b0, 8'h42}); want.push_back({1'b0, 8'h43});
        compare_log("single", want);

        // Contention after reset, then alternation
        busy_lo = 2; busy_hi = 2;
        apply_reset();
        log_q.delete();
        push_byte(0, 8'h10, 1'b0);
        push_byte(0, 8'h11, 1'b1);
        push_byte(1, 8'h20, 1'b1);
        wait_idle("contend1_idle");
        push_byte(0, 8'h12, 1'b1);
        push_byte(1, 8'h21, 1'b1);
        wait_idle("contend2_idle");
        want.delete();
        want.push_back({1'b0, 8'h10}); want.push_back({1'b0, 8'h11}); want.push_back({1'b1, 8'h20});
        want.push_back({1'b0, 8'h12}); want.push_back({1'b1, 8'h21});
        compare_log("contend", want);

        // Burst limit: req1 is served between req0's first four bytes and the rest
        log_q.delete();
        for (int i = 0; i < 10; i++) push_byte(0, 8'(8'hA0 + i), 1'b0);
        wait_grant("burst_grant0", 2'b01);
        push_byte(1, 8'hB0, 1'b0);
        push_byte(1, 8'hB1, 1'b1);
        wait_idle("burst_idle");
        want.delete();
        for (int i = 0; i < 4; i++) want.push_back({1'b0, 8'(8'hA0 + i)});
        want.push_back({1'b1, 8'hB0}); want.push_back({1'b1, 8'hB1});
        for (int i = 4; i < 10; i++) want.push_back({1'b0, 8'(8'hA0 + i)});
        compare_log("burst", want);

        // Idle timeout: grant dropped 8 cycles after re-entering LOAD
        busy_lo = 3; busy_hi = 3;
        log_q.delete();
        push_byte(0, 8'hC0, 1'b0);
        wait_strobe("timeout_strobe");
        push_byte(1, 8'hD0, 1'b1);
        @(negedge clk);
        wait_busy_low("timeout_drain");
        check("timeout_grant_in_drain", bus.grant, 2'b01);
        bad = 1'b0;
        repeat (IDLE_TIMEOUT) begin
            @(negedge clk);
            if (bus.grant != 2'b01 || bus.uart_tx_wr) bad = 1'b1;
        end
        check("timeout_hold_no_strobe", bad, 1'b0);
        @(negedge clk);
        check("timeout_release", bus.grant, 2'b00);
        @(negedge clk);
        check("timeout_next_grant", bus.grant, 2'b10);
        wait_idle("timeout_idle");
        want.delete();
        want.push_back({1'b0, 8'hC0}); want.push_back({1'b1, 8'hD0});
        compare_log("timeout", want);

        // Reset in the SEND cycle
        log_q.delete();
        push_byte(0, 8'hE0, 1'b1);
        wait_strobe("rst_strobe");
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr", bus.uart_tx_wr, 1'b0);
        check("rst_mid_grant", bus.grant, 2'b00);
        check("rst_mid_ready", bus.req_ready, 2'b00);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_q0.delete(); exp_q1.delete();
        @(negedge clk);
        push_byte(1, 8'hE1, 1'b1);
        @(negedge clk);
        check("rst_after_idle", bus.grant, 2'b00);
        @(negedge clk);
        check("rst_after_grant", bus.grant, 2'b10);
        wait_idle("rst_idle");

`ifdef UART_ARB_STATS_EN
        // Statistics counters and saturation
        apply_reset();
        for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h50 + i), i == 4);
        push_byte(1, 8'h60, 1'b0);
        push_byte(1, 8'h61, 1'b1);
        wait_idle("stats_idle");
        check("stat_bytes0", bus.stat_bytes0, 16'd5);
        check("stat_bytes1", bus.stat_bytes1, 16'd2);
        @(negedge clk);
        force dut.r_stat0 = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_stat0;
        push_byte(0, 8'h70, 1'b1);
        wait_idle("stats_sat_idle");
        check("stat_bytes0_saturated", bus.stat_bytes0, 16'hFFFF);
        check("stat_bytes1_unchanged", bus.stat_bytes1, 16'd2);
`endif

        // Randomized messages from both requesters
        busy_lo = 1; busy_hi = 6; gap_hi = 2;
        for (int m = 0; m < 40; m++) begin
            r   = int'($urandom_range(1, 0));
            len = int'($urandom_range(6, 1));
            for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
            repeat ($urandom_range(15, 0)) @(negedge clk);
        end
        wait_idle("random_idle");
        check("random_leftover0", exp_q0.size(), 32'd0);
        check("random_leftover1", exp_q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the SoC's single UART transmitter byte interface between two requesters, e.g. the CPU console path (requester 0) and a debug/trace source (requester 1).
- Round-robin arbitration at message granularity. The grant is held until the requester marks its last byte, a burst limit is reached, or the requester stalls too long.
- Sits between the requesters' byte streams and the UART tx_wr/tx_data/tx_busy port.

Parameters:
- MAX_BURST, 16: bytes sent under one grant before forced release (1..255).
- IDLE_TIMEOUT, 64: cycles a granted requester may hold req_valid low before the grant is revoked (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester byte valid
- req_data  in  16  packed bytes; [7:0] is requester 0, [15:8] is requester 1
- req_last  in  2  per-requester: current byte ends the message
- req_ready  out  2  per-requester byte accepted (combinational, one-hot or zero)
- grant  out  2  registered one-hot current owner; 0 when idle
- uart_tx_data  out  8  registered byte to UART
- uart_tx_wr  out  1  single-cycle write strobe to UART
- uart_tx_busy  in  1  UART shifting; asserted no later than the cycle after uart_tx_wr
- stat_bytes0, stat_bytes1  out  16 each  only with UART_ARB_STATS_EN

Behaviour:
- Reset (rst=0, immediate): grant=0, uart_tx_wr=0, uart_tx_data=0, burst_cnt=0, idle_cnt=0, rr_ptr=0 (requester 0 favoured), state IDLE.
- A reset mid-byte drops the strobe at once; the UART sees no further writes.
- State IDLE:
  - grant=0, req_ready=0.
  - If only one req_valid is high, that requester wins.
  - If both are high, the winner is rr_ptr.
  - Next cycle: grant=winner, rr_ptr=~winner, burst_cnt=0, idle_cnt=0, state LOAD.
- State LOAD:
  - If req_valid[g] and !uart_tx_busy: req_ready[g]=1 this cycle; capture req_data byte and req_last[g] into last_f; next state SEND.
  - If req_valid[g]=0: idle_cnt increments. At idle_cnt==IDLE_TIMEOUT-1, go to IDLE (grant released next cycle).
  - Any accepted byte clears idle_cnt.
- State SEND:
  - uart_tx_wr=1 for exactly this cycle, with uart_tx_data stable.
  - burst_cnt increments; next state GUARD.
- State GUARD: one cycle for the UART to raise busy; next state DRAIN.
- State DRAIN: wait for uart_tx_busy=0, then:
  - if last_f or burst_cnt==MAX_BURST, go to IDLE;
  - otherwise go to LOAD.
- Throughput:
  - Minimum 4 cycles per byte (LOAD, SEND, GUARD, DRAIN) plus UART busy time.
  - Grant latency is 1 cycle from req_valid in IDLE.
- req_ready is never asserted to the non-granted requester. Data from the non-granted requester is ignored and never lost; it waits, with valid held.
- Requesters must hold req_data/req_last stable while valid and not ready.
- Forced release at MAX_BURST:
  - The message continues at the next grant.
  - If the other requester is waiting, it is served first (rr_ptr).
- uart_tx_busy high in LOAD means wait; no byte is accepted.
- burst_cnt is 8 bits wide and never wraps; it is compared with equality against MAX_BURST.

Optional Feature:
- Macro: UART_ARB_STATS_EN.
- Defined:
  - stat_bytes0/stat_bytes1 count bytes strobed per requester, incremented in SEND.
  - Each saturates at 16'hFFFF and resets to 0 on rst.
- Undefined: the ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Single message: req0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), with tx_busy modelled as 10 cycles.
  - Expect exactly 3 uart_tx_wr strobes with data in order.
  - Expect grant=2'b01 throughout, and grant=0 one cycle after the final DRAIN.
- Contention after reset: both valid in the same cycle.
  - Expect grant=2'b01 first; after req0's last byte, grant=2'b10.
  - A second simultaneous request after that favours req0 again (alternation).
- Burst limit: MAX_BURST=4, req0 streams 10 bytes with no last while req1 is waiting.
  - Expect bytes 0-3 from req0, then req1's message, then req0 bytes 4-9.
- Idle timeout: IDLE_TIMEOUT=8; req0 is granted and sends 1 byte (not last), then drops valid.
  - Expect grant=0 exactly 8 cycles after entering LOAD, with no strobe.
  - A pending req1 is then granted.
- Reset mid-operation: assert rst low in the SEND cycle.
  - Expect uart_tx_wr=0, grant=0 and req_ready=0 immediately.
  - After release, req1 alone is granted in 1 cycle.
- Stats (with UART_ARB_STATS_EN): send 5 bytes on req0 and 2 bytes on req1.
  - Expect stat_bytes0=5 and stat_bytes1=2.
  - Force stat_bytes0 to 16'hFFFF, send one more byte, and expect it to stay at 16'hFFFF.
